// File: rtl/sdram_arbiter_rr.sv
// sdram_arbiter_rr: round-robin arbiter for N masters in front of the SDRAM controller, with optional high-priority group and ID-routed read responses.
// Latency: grant (m_ready) is combinational in the request cycle; the command appears on sdram_* one cycle later; responses route with zero latency.
// Backpressure: sdram_ready low holds every sdram_* register and withholds all m_ready; requests are never latched, so masters just keep requesting.
//
// Ports:
//   clk, reset                      clock and synchronous active-high reset
//   m_request/m_write/m_burst       per-master request and command qualifiers
//   m_address/m_wdata/m_wstrb       packed per-master command fields (master k at slice k)
//   m_ready                         one-hot grant, combinational
//   m_rvalid/m_complete             one-hot response strobes decoded from sdram_rvalid
//   m_raddress/m_rdata              broadcast read address/data
//   sdram_request..sdram_wdata      registered command to the controller (ID 0 = none)
//   sdram_ready                     controller accepts a new command this cycle
//   sdram_raddress/rdata/rvalid/complete  controller response
//   err_bad_id                      sticky flag for a response ID with no master behind it
module sdram_arbiter_rr #(
    parameter int NUM_MASTERS = 5,
    parameter int ADDR_W      = 26,
    parameter int DATA_W      = 32,
    parameter int ID_W        = $clog2(NUM_MASTERS + 1),
    parameter logic [NUM_MASTERS-1:0] HI_PRIO_MASK = '0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_MASTERS-1:0]          m_request,
    output logic [NUM_MASTERS-1:0]          m_ready,
    input  logic [NUM_MASTERS-1:0]          m_write,
    input  logic [NUM_MASTERS-1:0]          m_burst,
    input  logic [NUM_MASTERS*ADDR_W-1:0]   m_address,
    input  logic [NUM_MASTERS*DATA_W-1:0]   m_wdata,
    input  logic [NUM_MASTERS*DATA_W/8-1:0] m_wstrb,
    output logic [NUM_MASTERS-1:0]          m_rvalid,
    output logic [ADDR_W-1:0]               m_raddress,
    output logic [DATA_W-1:0]               m_rdata,
    output logic [NUM_MASTERS-1:0]          m_complete,
    output logic [ID_W-1:0]                 sdram_request,
    input  logic                            sdram_ready,
    output logic [ADDR_W-1:0]               sdram_address,
    output logic                            sdram_write,
    output logic                            sdram_burst,
    output logic [DATA_W/8-1:0]             sdram_wstrb,
    output logic [DATA_W-1:0]               sdram_wdata,
    input  logic [ADDR_W-1:0]               sdram_raddress,
    input  logic [DATA_W-1:0]               sdram_rdata,
    input  logic [ID_W-1:0]                 sdram_rvalid,
    input  logic                            sdram_complete,
    output logic                            err_bad_id
);

    localparam int STRB_W = DATA_W / 8;
    localparam int PTR_W  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    logic [PTR_W-1:0]       last_grant;
    logic [NUM_MASTERS-1:0] cand;
    logic [PTR_W-1:0]       winner;
    logic                   found;
    logic                   grant_en;
    int                     idx;

    logic [ADDR_W-1:0]      win_address;
    logic [DATA_W-1:0]      win_wdata;
    logic [STRB_W-1:0]      win_wstrb;
    logic                   win_write;
    logic                   win_burst;
    logic                   bad_id;

    // Winner search: the high-priority group, if any of it is requesting,
    // hides everyone else; then scan upward from the slot after the last
    // winner, wrapping, so each requester gets its turn.
    always_comb begin
        cand   = ((HI_PRIO_MASK & m_request) != '0) ? (HI_PRIO_MASK & m_request) : m_request;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            idx = (int'(last_grant) + 1 + i) % NUM_MASTERS;
            if (!found && cand[idx]) begin
                found  = 1'b1;
                winner = PTR_W'(idx);
            end
        end
    end

    // A grant only happens when the controller can take the command and we
    // are not in reset; reset wins over a simultaneous grant.
    assign grant_en = found && sdram_ready && !reset;

    always_comb begin
        m_ready     = '0;
        win_address = '0;
        win_wdata   = '0;
        win_wstrb   = '0;
        win_write   = 1'b0;
        win_burst   = 1'b0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (winner == PTR_W'(k)) begin
                m_ready[k]  = grant_en;
                win_address = m_address[k*ADDR_W +: ADDR_W];
                win_wdata   = m_wdata[k*DATA_W +: DATA_W];
                win_wstrb   = m_wstrb[k*STRB_W +: STRB_W];
                win_write   = m_write[k];
                win_burst   = m_burst[k];
            end
        end
    end

    // Response routing: ID k+1 belongs to master k; it is independent of the
    // grant path and of reset.
    always_comb begin
        m_rvalid   = '0;
        m_complete = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (sdram_rvalid == ID_W'(k + 1)) begin
                m_rvalid[k]   = 1'b1;
                m_complete[k] = sdram_complete;
            end
        end
    end

    assign bad_id     = int'(sdram_rvalid) > NUM_MASTERS;
    assign m_raddress = sdram_raddress;
    assign m_rdata    = sdram_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant    <= PTR_W'(NUM_MASTERS - 1);
            sdram_request <= '0;
            sdram_address <= '0;
            sdram_write   <= 1'b0;
            sdram_burst   <= 1'b0;
            sdram_wstrb   <= '0;
            sdram_wdata   <= '0;
            err_bad_id    <= 1'b0;
        end else begin
            if (bad_id) begin
                err_bad_id <= 1'b1;
            end
            // With sdram_ready low the previous command stays on the bus.
            if (sdram_ready) begin
                if (found) begin
                    last_grant    <= winner;
                    sdram_request <= ID_W'(winner) + ID_W'(1);
                    sdram_address <= win_address;
                    sdram_write   <= win_write;
                    sdram_burst   <= win_burst;
                    sdram_wstrb   <= win_wstrb;
                    sdram_wdata   <= win_wdata;
                end else begin
                    sdram_request <= '0;
                    sdram_address <= '0;
                    sdram_write   <= 1'b0;
                    sdram_burst   <= 1'b0;
                    sdram_wstrb   <= '0;
                    sdram_wdata   <= '0;
                end
            end
        end
    end

endmodule
